// File: rtl/tlc_demand_detector.sv
// Purpose: conditions loop sensors into MD/SD demands, retires them on service, flags illegal lights.
// Latency: demand rises DEBOUNCE+2 edges after the loop goes high; fault is set one edge after a bad light combination.
// Backpressure: none; every input is sampled every cycle and outputs are plain registers.

module tlc_demand_fsm #(
    parameter int DEBOUNCE = 4,
    parameter int WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              loop_i,
    input  logic              served_i,
    output logic              demand_o,
    output logic [WAIT_W-1:0] wait_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        DEMAND = 2'd2,
        SERVED = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [8:0]        DEB_TGT  = 9'(DEBOUNCE);

    logic              sync1_q, sync2_q;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [8:0]        cnt_inc;
    logic              cnt_hit;
    logic              md_q, md_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Two-flop synchronizer for the asynchronous loop sensor; only the second stage feeds the FSM.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= loop_i;
            sync2_q <= sync1_q;
        end
    end

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign cnt_hit = (cnt_inc == DEB_TGT);

    // Next-state logic: the counter qualifies loop presence in QUAL and loop absence in SERVED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = QUAL;
                    cnt_d   = 8'd1;
                end
            end
            QUAL: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_hit) begin
                    // A car that qualifies while already on green needs no demand.
                    state_d = served_i ? SERVED : DEMAND;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            DEMAND: begin
                // Loop dropouts are ignored here: the demand stays latched until served.
                if (served_i) begin
                    state_d = SERVED;
                    cnt_d   = 8'd0;
                end
            end
            SERVED: begin
                if (!served_i && sync2_q) begin
                    // Green ended with a car still on the loop.
                    state_d = DEMAND;
                    cnt_d   = 8'd0;
                end else if (sync2_q) begin
                    cnt_d = 8'd0;
                end else if (cnt_hit) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Demand output and wait counter; the counter only advances while DEMAND persists across the edge,
    // so it reads 0 on entry and is already 0 on the edge that retires the demand.
    always_comb begin
        md_d   = (state_d == DEMAND);
        wait_d = '0;
        if (state_q == DEMAND && state_d == DEMAND) begin
            wait_d = (&wait_q) ? wait_q : (wait_q + WAIT_ONE);
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            md_q    <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_q    <= md_d;
            wait_q  <= wait_d;
        end
    end

    assign demand_o = md_q;
    assign wait_o   = wait_q;

endmodule

module tlc_demand_detector #(
    parameter int DEBOUNCE = 4,
    parameter int WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              loop_m,
    input  logic              loop_s,
    input  logic              MR,
    input  logic              MY,
    input  logic              MG,
    input  logic              MA,
    input  logic              SR,
    input  logic              SY,
    input  logic              SG,
    output logic              MD,
    output logic              SD,
    output logic [WAIT_W-1:0] m_wait,
    output logic [WAIT_W-1:0] s_wait,
    output logic              fault
);

    logic       g_m, g_s;
    logic [1:0] m_lit, s_lit;
    logic       illegal;
    logic       fault_q, fault_d;

    assign g_m = MG | MA;
    assign g_s = SG;

    tlc_demand_fsm #(.DEBOUNCE(DEBOUNCE), .WAIT_W(WAIT_W)) u_main (
        .clk      (clk),
        .clr_n    (clr_n),
        .loop_i   (loop_m),
        .served_i (g_m),
        .demand_o (MD),
        .wait_o   (m_wait)
    );

    tlc_demand_fsm #(.DEBOUNCE(DEBOUNCE), .WAIT_W(WAIT_W)) u_side (
        .clk      (clk),
        .clr_n    (clr_n),
        .loop_i   (loop_s),
        .served_i (g_s),
        .demand_o (SD),
        .wait_o   (s_wait)
    );

    // Light-conflict check on the raw controller outputs; the arrow is only legal alongside main green.
    always_comb begin
        m_lit   = {1'b0, MR} + {1'b0, MY} + {1'b0, MG};
        s_lit   = {1'b0, SR} + {1'b0, SY} + {1'b0, SG};
        illegal = (m_lit != 2'd1) || (s_lit != 2'd1) || (MA && !MG) ||
                  ((MY || MG || MA) && (SY || SG));
        fault_d = fault_q | illegal;
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

endmodule
